// File: rtl/utoss_riscv_core_pkg.sv
// Shared types, opcode constants and small combinational helpers for the multicycle RV32I core.
package utoss_riscv_core_pkg;

  typedef enum logic [1:0] {
    PC_SRC__INCR,
    PC_SRC__JUMP,
    PC_SRC__ALU_RESULT
  } pc_src_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    UNCONDJUMP
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct7[5] selects SUB only for register ops; for shifts it selects SRA in both forms.
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3, input logic funct7_b5,
                                            input logic is_reg);
    alu_op_t op;
    unique case (funct3)
      3'b000:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu_compute(input alu_op_t op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] r;
    unique case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] imm_decode(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = {{20{ir[31]}}, ir[31:20]};
      OPC_STORE:                      imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:             imm = {ir[31:12], 12'b0};
      OPC_JAL:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                        imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/utoss_riscv_core_control_fsm.sv
// Control sequencer: steps each instruction through fetch/decode/execute and raises datapath strobes.
module utoss_riscv_core_control_fsm
  import utoss_riscv_core_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_opcode,
  input  logic       i_branch_taken,
  output state_t     o_state,
  output logic       o_ir_write,
  output logic       o_pc_update,
  output pc_src_t    o_pc_src,
  output logic       o_alu_latch,
  output logic       o_mdr_latch,
  output logic       o_rf_write,
  output logic       o_rf_from_mem,
  output logic       o_mem_write
);

  state_t current_state;
  state_t w_next_state;

  always_ff @(posedge i_clk) begin
    if (i_reset) current_state <= FETCH;
    else         current_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = FETCH;
    o_ir_write    = 1'b0;
    o_pc_update   = 1'b0;
    o_pc_src      = PC_SRC__INCR;
    o_alu_latch   = 1'b0;
    o_mdr_latch   = 1'b0;
    o_rf_write    = 1'b0;
    o_rf_from_mem = 1'b0;
    o_mem_write   = 1'b0;
    unique case (current_state)
      FETCH: begin
        o_ir_write   = 1'b1;
        o_pc_update  = 1'b1;
        w_next_state = DECODE;
      end
      DECODE: begin
        case (i_opcode)
          OPC_OP:                        w_next_state = EXECUTER;
          OPC_OP_IMM, OPC_LUI, OPC_AUIPC: w_next_state = EXECUTEI;
          OPC_LOAD, OPC_STORE:           w_next_state = MEMADR;
          OPC_BRANCH:                    w_next_state = BRANCH;
          OPC_JAL, OPC_JALR:             w_next_state = UNCONDJUMP;
          default:                       w_next_state = FETCH;
        endcase
      end
      MEMADR: begin
        o_alu_latch  = 1'b1;
        w_next_state = (i_opcode == OPC_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        o_mdr_latch  = 1'b1;
        w_next_state = MEMWB;
      end
      MEMWB: begin
        o_rf_write    = 1'b1;
        o_rf_from_mem = 1'b1;
      end
      MEMWRITE: o_mem_write = 1'b1;
      EXECUTER, EXECUTEI: begin
        o_alu_latch  = 1'b1;
        w_next_state = ALUWB;
      end
      UNCONDJUMP: begin
        o_alu_latch  = 1'b1;
        o_pc_update  = 1'b1;
        o_pc_src     = PC_SRC__JUMP;
        w_next_state = ALUWB;
      end
      ALUWB: o_rf_write = 1'b1;
      BRANCH: begin
        o_pc_update = i_branch_taken;
        o_pc_src    = PC_SRC__JUMP;
      end
      default: w_next_state = FETCH;
    endcase
  end

  assign o_state = current_state;

endmodule

// File: rtl/utoss_riscv_core.sv
// Multicycle RV32I core with a unified word memory; datapath pieces live in named blocks so
// benches can reach fetch, memory, RegFile, alu and instruction_decode state hierarchically.
module utoss_riscv_core
  import utoss_riscv_core_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [6:0]  opcode;
  logic        cfsm__pc_update;
  pc_src_t     cfsm__pc_src;

  state_t      w_state;
  logic        w_ir_write, w_alu_latch, w_mdr_latch;
  logic        w_rf_write, w_rf_from_mem, w_mem_write, w_branch_taken;
  logic [31:0] w_ir, w_pc_cur, w_pc_old, w_imm;
  logic [31:0] w_rs1_val, w_rs2_val, w_alu_out, w_imem_rdata, w_dmem_rdata;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] r_alu_result, r_mdr;
  logic        w_unused;

  utoss_riscv_core_control_fsm control_fsm (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_opcode       (opcode),
    .i_branch_taken (w_branch_taken),
    .o_state        (w_state),
    .o_ir_write     (w_ir_write),
    .o_pc_update    (cfsm__pc_update),
    .o_pc_src       (cfsm__pc_src),
    .o_alu_latch    (w_alu_latch),
    .o_mdr_latch    (w_mdr_latch),
    .o_rf_write     (w_rf_write),
    .o_rf_from_mem  (w_rf_from_mem),
    .o_mem_write    (w_mem_write)
  );

  if (1'b1) begin : fetch
    logic [31:0] pc_cur, pc_old, IR, w_pc_next;

    always_comb begin
      w_pc_next = pc_cur + 32'd4;
      case (cfsm__pc_src)
        PC_SRC__JUMP: w_pc_next = (opcode == OPC_JALR) ? ((w_rs1_val + w_imm) & ~32'd1)
                                                       : (pc_old + w_imm);
        PC_SRC__ALU_RESULT: w_pc_next = w_alu_out;
        default: w_pc_next = pc_cur + 32'd4;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        pc_cur <= RESET_PC;
        pc_old <= RESET_PC;
        IR     <= '0;
      end else begin
        if (cfsm__pc_update) pc_cur <= w_pc_next;
        if (w_ir_write) begin
          IR     <= w_imem_rdata;
          pc_old <= pc_cur;
        end
      end
    end

    assign w_pc_cur = pc_cur;
    assign w_pc_old = pc_old;
    assign w_ir     = IR;
  end

  // Not reset: contents are preloaded and must survive reset.
  if (1'b1) begin : memory
    logic [31:0]   M [MEM_WORDS];
    logic [AW-1:0] w_iidx, w_didx;

    assign w_iidx       = w_pc_cur[AW+1:2];
    assign w_didx       = r_alu_result[AW+1:2];
    assign w_imem_rdata = M[w_iidx];
    assign w_dmem_rdata = M[w_didx];

    always_ff @(posedge clk) begin
      if (!reset && w_mem_write) M[w_didx] <= w_rs2_val;
    end
  end

  if (1'b1) begin : instruction_decode
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_ext;

    assign rd      = w_ir[11:7];
    assign rs1     = w_ir[19:15];
    assign rs2     = w_ir[24:20];
    assign funct3  = w_ir[14:12];
    assign funct7  = w_ir[31:25];
    assign imm_ext = imm_decode(w_ir);

    assign opcode   = w_ir[6:0];
    assign w_rd     = rd;
    assign w_rs1    = rs1;
    assign w_rs2    = rs2;
    assign w_funct3 = funct3;
    assign w_funct7 = funct7;
    assign w_imm    = imm_ext;
  end

  if (1'b1) begin : RegFile
    logic [31:0] RFMem [32];

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : RFMem[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : RFMem[w_rs2];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) RFMem[i] <= '0;
      end else if (w_rf_write && (w_rd != 5'd0)) begin
        RFMem[w_rd] <= w_rf_from_mem ? r_mdr : r_alu_result;
      end
    end
  end

  if (1'b1) begin : alu
    logic [31:0] a, b, out;
    alu_op_t     op;

    always_comb begin
      a  = w_rs1_val;
      b  = w_rs2_val;
      op = ALU_ADD;
      case (w_state)
        EXECUTER: op = alu_op_decode(w_funct3, w_funct7[5], 1'b1);
        EXECUTEI: begin
          b = w_imm;
          if (opcode == OPC_LUI)        a  = 32'd0;
          else if (opcode == OPC_AUIPC) a  = w_pc_old;
          else                          op = alu_op_decode(w_funct3, w_funct7[5], 1'b0);
        end
        MEMADR:     b = w_imm;
        UNCONDJUMP: begin
          a = w_pc_old;
          b = 32'd4;
        end
        BRANCH: begin
          unique case (w_funct3[2:1])
            2'b10:   op = ALU_SLT;
            2'b11:   op = ALU_SLTU;
            default: op = ALU_SUB;
          endcase
        end
        default: op = ALU_ADD;
      endcase
      out = alu_compute(op, a, b);
    end

    assign w_alu_out = out;
  end

  always_comb begin
    w_branch_taken = 1'b0;
    case (w_funct3)
      3'b000:       w_branch_taken = (w_alu_out == 32'd0);
      3'b001:       w_branch_taken = (w_alu_out != 32'd0);
      3'b100, 3'b110: w_branch_taken = w_alu_out[0];
      3'b101, 3'b111: w_branch_taken = ~w_alu_out[0];
      default:      w_branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_result <= '0;
      r_mdr        <= '0;
    end else begin
      if (w_alu_latch) r_alu_result <= w_alu_out;
      if (w_mdr_latch) r_mdr        <= w_dmem_rdata;
    end
  end

  assign w_unused = ^{w_pc_cur[31:AW+2], w_pc_cur[1:0], w_funct7[6], w_funct7[4:0]};

endmodule

// File: tb/tb_utoss_riscv_core.sv
// Bench for utoss_riscv_core: a straight-line program table checked per instruction via a
// scoreboard queue, plus hand-stepped JAL and reset-abort sequences.
module tb_utoss_riscv_core;
  import utoss_riscv_core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  utoss_riscv_core dut (
    .clk   (clk),
    .reset (reset)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    int          lat;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] next_pc;
  } vec_t;

  typedef struct {
    int          lat;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] next_pc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6F};
  endfunction

  task automatic add(input logic [31:0] pc, input logic [31:0] insn, input int lat,
      input logic [4:0] rd, input logic [31:0] val, input logic [31:0] nxt);
    vecs.push_back('{pc, insn, lat, rd, val, nxt});
    dut.memory.M[pc[11:2]] = insn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int   n;
    exp_t e;
    reset = 1'b1;

    // Unexecuted slots hold ADDI x17,x0,1 so a wrongly taken path leaves a trace in x17.
    for (int i = 0; i < 80; i++) dut.memory.M[i] = enc_i(1, 0, 0, 17, 7'h13);

    add(32'h00, enc_i(-1, 0, 0, 2, 7'h13),      4, 2,  32'hFFFF_FFFF, 32'h04);
    add(32'h04, enc_i(1, 2, 0, 3, 7'h13),       4, 3,  32'h0000_0000, 32'h08);
    add(32'h08, enc_u(20'h12345, 5, 7'h37),     4, 5,  32'h1234_5000, 32'h0C);
    add(32'h0C, enc_i(12'h678, 5, 0, 6, 7'h13), 4, 6,  32'h1234_5678, 32'h10);
    add(32'h10, enc_r(7'h00, 2, 6, 3'd0, 7),    4, 7,  32'h1234_5677, 32'h14);
    add(32'h14, enc_r(7'h20, 6, 3, 3'd0, 8),    4, 8,  32'hEDCB_A988, 32'h18);
    add(32'h18, enc_r(7'h00, 3, 2, 3'd2, 9),    4, 9,  32'h0000_0001, 32'h1C);
    add(32'h1C, enc_r(7'h00, 2, 3, 3'd3, 10),   4, 10, 32'h0000_0001, 32'h20);
    add(32'h20, enc_i(12'h404, 8, 5, 11, 7'h13), 4, 11, 32'hFEDC_BA98, 32'h24);
    add(32'h24, enc_i(4, 8, 5, 12, 7'h13),      4, 12, 32'h0EDC_BA98, 32'h28);
    add(32'h28, enc_i(4, 6, 1, 13, 7'h13),      4, 13, 32'h2345_6780, 32'h2C);
    add(32'h2C, enc_i(255, 6, 4, 14, 7'h13),    4, 14, 32'h1234_5687, 32'h30);
    add(32'h30, enc_u(20'h00001, 15, 7'h17),    4, 15, 32'h0000_1030, 32'h34);
    add(32'h34, enc_s(12'h100, 6, 0),           4, 0,  32'h0000_0000, 32'h38);
    add(32'h38, enc_i(12'h100, 0, 2, 16, 7'h03), 5, 16, 32'h1234_5678, 32'h3C);
    add(32'h3C, enc_i(5, 0, 0, 0, 7'h13),       4, 0,  32'h0000_0000, 32'h40);
    add(32'h40, enc_b(8, 0, 0, 3'd1),           3, 0,  32'h0000_0000, 32'h44);
    add(32'h44, enc_b(8, 0, 0, 3'd0),           3, 0,  32'h0000_0000, 32'h4C);
    add(32'h4C, enc_j(8, 1),                    4, 1,  32'h0000_0050, 32'h54);
    add(32'h54, enc_i(16, 1, 0, 18, 7'h67),     4, 18, 32'h0000_0058, 32'h60);
    add(32'h60, enc_b(8, 3, 2, 3'd4),           3, 0,  32'h0000_0000, 32'h68);
    add(32'h68, enc_b(8, 3, 2, 3'd7),           3, 0,  32'h0000_0000, 32'h70);
    add(32'h70, enc_b(8, 3, 2, 3'd6),           3, 0,  32'h0000_0000, 32'h74);
    add(32'h74, enc_b(8, 2, 3, 3'd5),           3, 0,  32'h0000_0000, 32'h7C);
    add(32'h7C, enc_r(7'h00, 2, 6, 3'd6, 19),   4, 19, 32'hFFFF_FFFF, 32'h80);
    add(32'h80, enc_i(12'h0F0, 6, 7, 20, 7'h13), 4, 20, 32'h0000_0070, 32'h84);
    add(32'h84, enc_r(7'h00, 2, 8, 3'd5, 21),   4, 21, 32'h0000_0001, 32'h88);
    add(32'h88, 32'h0000_0073,                  2, 0,  32'h0000_0000, 32'h8C);
    add(32'h8C, enc_b(-12, 0, 0, 3'd0),         3, 0,  32'h0000_0000, 32'h80);

    repeat (2) step();
    check("rst_state", dut.control_fsm.current_state, FETCH);
    check("rst_pc_cur", dut.fetch.pc_cur, 32'h0);
    check("rst_pc_old", dut.fetch.pc_old, 32'h0);
    check("rst_ir", dut.fetch.IR, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].lat, vecs[i].rd, vecs[i].val, vecs[i].next_pc});
      check($sformatf("v%0d_pc_start", i), dut.fetch.pc_cur, vecs[i].pc);
      n = 0;
      do begin
        step();
        n++;
      end while (dut.control_fsm.current_state != FETCH && n < 12);
      e = sb.pop_front();
      check($sformatf("v%0d_latency", i), n, e.lat);
      check($sformatf("v%0d_next_pc", i), dut.fetch.pc_cur, e.next_pc);
      check($sformatf("v%0d_x%0d", i, e.rd), dut.RegFile.RFMem[e.rd], e.val);
    end
    check("store_mem", dut.memory.M[64], 32'h1234_5678);
    check("skipped_x17", dut.RegFile.RFMem[17], 32'h0);

    // JAL x1,+16 stepped state by state.
    dut.memory.M[0] = enc_j(16, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("jal_rst_state", dut.control_fsm.current_state, FETCH);
    step();
    check("jal_decode_state", dut.control_fsm.current_state, DECODE);
    check("jal_opcode", dut.opcode, 32'h6F);
    check("jal_rd", dut.instruction_decode.rd, 32'd1);
    check("jal_imm", dut.instruction_decode.imm_ext, 32'd16);
    step();
    check("jal_uj_state", dut.control_fsm.current_state, UNCONDJUMP);
    check("jal_alu_a", dut.alu.a, 32'd0);
    check("jal_alu_b", dut.alu.b, 32'd4);
    check("jal_alu_out", dut.alu.out, 32'd4);
    check("jal_pc_update", dut.cfsm__pc_update, 32'd1);
    check("jal_pc_src", dut.cfsm__pc_src, PC_SRC__JUMP);
    step();
    check("jal_wb_state", dut.control_fsm.current_state, ALUWB);
    step();
    check("jal_end_state", dut.control_fsm.current_state, FETCH);
    check("jal_link", dut.RegFile.RFMem[1], 32'd4);
    check("jal_pc", dut.fetch.pc_cur, 32'd16);

    // Reset landing in EXECUTER must abort the ADD without writing x23.
    dut.memory.M[0] = enc_i(7, 0, 0, 22, 7'h13);
    dut.memory.M[1] = enc_r(7'h00, 22, 22, 3'd0, 23);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
    check("abort_x22", dut.RegFile.RFMem[22], 32'd7);
    repeat (2) step();
    check("abort_in_execr", dut.control_fsm.current_state, EXECUTER);
    reset = 1'b1;
    step();
    check("abort_state", dut.control_fsm.current_state, FETCH);
    check("abort_pc", dut.fetch.pc_cur, 32'd0);
    check("abort_x23", dut.RegFile.RFMem[23], 32'd0);
    reset = 1'b0;
    repeat (8) step();
    check("rerun_x23", dut.RegFile.RFMem[23], 32'd14);
    check("rerun_pc", dut.fetch.pc_cur, 32'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
